count_capture: RTL and testbench
================================

COUNT_CAPTURE -- requirements
Module: count_capture

Interface
REQ-001 Parameter COUNT_W, default 33, SHALL set the width of the captured counter value.
REQ-002 Parameter DEPTH, default 8, power of two >= 2, SHALL set the capture FIFO depth.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 count  input  COUNT_W  free-running counter value from the upstream counter, synchronous to clk.
REQ-006 arm  input  1  capture enable, synchronous.
REQ-007 event_in  input  1  asynchronous event strobe; its rising edge requests a capture.
REQ-008 out_valid  output  1  FIFO head valid.
REQ-009 out_data  output  COUNT_W  FIFO head captured value.
REQ-010 out_ready  input  1  consumer accepts the head.
REQ-011 level  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
REQ-012 overflow  output  1  sticky flag; a capture was dropped.
REQ-013 drop_cnt  output  8  number of dropped captures, saturating.
REQ-014 clear_ovf  input  1  synchronous pulse; clears overflow and drop_cnt.

Function
REQ-015 event_in SHALL pass through a 2-flop synchronizer (s1, s2) followed by one history flop (s3); cap_pulse = s2 & ~s3.
REQ-016 When event_in rises before clk edge N, cap_pulse SHALL be high for exactly one cycle, between edges N+1 and N+2.
REQ-017 At an edge where cap_pulse=1 and arm=1, the block SHALL push the count value sampled at that same edge.
REQ-018 cap_pulse with arm=0 SHALL be discarded: no push, no overflow.
REQ-019 The FIFO SHALL be first-word fall-through: out_valid = (level != 0), and out_data = oldest entry.
REQ-020 A pop SHALL occur at an edge where out_valid=1 and out_ready=1.
REQ-021 A pushed value SHALL appear on out_data with out_valid=1 in the cycle after the push edge, when the FIFO was empty.
REQ-022 out_data SHALL be held stable while out_valid=1 and out_ready=0.
REQ-023 Push and pop at the same edge SHALL both occur at any level, including full, and level SHALL be unchanged.
REQ-024 Push when full without a pop SHALL drop the value, set overflow, and increment drop_cnt, saturating at 255.
REQ-025 Pop when empty SHALL be ignored.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH.
REQ-027 clear_ovf=1 SHALL clear overflow and drop_cnt at that edge; a simultaneous drop SHALL win, giving overflow=1 and drop_cnt=1.
REQ-028 count SHALL be captured verbatim with no arithmetic; a count wrap-around SHALL need no special handling.

Reset
REQ-029 rst_n=0 SHALL asynchronously clear s1, s2, s3, the pointers, level, overflow and drop_cnt.
REQ-030 During reset and after it, outputs SHALL be out_valid=0, level=0, overflow=0, drop_cnt=0, out_data=0.
REQ-031 Reset asserted mid-operation SHALL discard all FIFO contents and any in-flight synchronizer edge.
REQ-032 FIFO storage RAM SHALL NOT require a reset.

Structure
REQ-033 Shared package count_pkg SHALL hold COUNT_W default (33), DEPTH default (8) and the drop counter width (8).
REQ-034 Sub-module capture_fifo SHALL implement the FWFT FIFO, with push/pop, level, full and empty.
REQ-035 The top level SHALL hold the synchronizer, the edge detect, arm gating and the overflow/drop logic.

Verification
REQ-036 Reset, then one event_in rise before edge N with count=100 at edge N+2 and arm=1 -> out_valid rises after N+2 and out_data=100.
REQ-037 arm=0 with three events -> level stays 0, overflow=0.
REQ-038 out_ready=0 with 10 captures at DEPTH=8 -> level=8, overflow=1, drop_cnt=2, then out_ready=1 -> the 8 oldest values drain in order.
REQ-039 Full FIFO with capture and pop at the same edge -> level stays 8, overflow unchanged, newest value lands at the tail.
REQ-040 clear_ovf coincident with a drop -> overflow=1, drop_cnt=1; 300 drops -> drop_cnt=255.
REQ-041 rst_n asserted with level=5 and an edge pending in s1/s2 -> level=0 and no capture after release.

Source files
------------

// File: rtl/count_pkg.sv
// count_capture shared definitions.
// Default sizes and helpers for the capture path.
package count_pkg;

    localparam int COUNT_W_DEF = 33;
    localparam int DEPTH_DEF   = 8;
    localparam int DROP_W      = 8;

    function automatic logic [DROP_W-1:0] sat_inc(
        input logic [DROP_W-1:0] v
    );
        return (&v) ? v : v + DROP_W'(1);
    endfunction

endpackage

// File: rtl/count_capture_if.sv
// count_capture output stream.
// FWFT head with valid/ready handshake.
interface count_capture_if
    import count_pkg::*;
#(
    parameter int W = COUNT_W_DEF
) ();

    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/capture_fifo.sv
// capture_fifo: first-word fall-through FIFO.
// A push into a full FIFO is taken only with a pop.
module capture_fifo
    import count_pkg::*;
#(
    parameter int  W     = COUNT_W_DEF,
    parameter int  DEPTH = DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage needs no reset; only valid entries are ever shown.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/count_capture.sv
// count_capture: timestamps async events into a FIFO.
// Drops on full are counted and flagged sticky.
module count_capture
    import count_pkg::*;
#(
    parameter int  COUNT_W = COUNT_W_DEF,
    parameter int  DEPTH   = DEPTH_DEF,
    localparam int LW      = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COUNT_W-1:0] count,
    input  logic               arm,
    input  logic               event_in,
    count_capture_if.master    bus,
    output logic [LW-1:0]      level,
    output logic               overflow,
    output logic [DROP_W-1:0]  drop_cnt,
    input  logic               clear_ovf
);

    logic s1;
    logic s2;
    logic s3;
    logic cap_pulse;
    logic req;
    logic full;
    logic empty;
    logic pop_ok;
    logic drop;

    assign cap_pulse     = s2 & ~s3;
    assign req           = cap_pulse & arm;
    assign pop_ok        = bus.out_ready & ~empty;
    assign drop          = req & full & ~pop_ok;
    assign bus.out_valid = ~empty;

    // Two-flop synchronizer plus history flop for rise detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= event_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    capture_fifo #(
        .W     (COUNT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req),
        .din   (count),
        .pop   (bus.out_ready),
        .dout  (bus.out_data),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    // Sticky overflow; a drop in the clear cycle still counts as one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= clear_ovf ? DROP_W'(1) : sat_inc(drop_cnt);
        end else if (clear_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_count_capture.sv
// tb_count_capture: directed checks of count_capture.
// Inputs driven 1ns after rising edges, outputs sampled there too.
module tb_count_capture;

    localparam int W  = 33;
    localparam int D  = 8;
    localparam int LW = 4;

    localparam logic [W-1:0] BASE  = 33'h1_0000_0000;
    localparam logic [W-1:0] BASE2 = 33'h0_5555_0000;
    localparam logic [W-1:0] VNEW  = 33'h1_ABCD_0001;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  count;
    logic          arm;
    logic          event_in;
    logic          clear_ovf;
    logic [LW-1:0] level;
    logic          overflow;
    logic [7:0]    drop_cnt;

    int n_pass  = 0;
    int n_total = 0;

    count_capture_if #(.W(W)) bus ();

    count_capture #(
        .COUNT_W (W),
        .DEPTH   (D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .count     (count),
        .arm       (arm),
        .event_in  (event_in),
        .bus       (bus),
        .level     (level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .clear_ovf (clear_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One event rise; val is on count only at the push edge.
    task automatic capture(
        input logic [W-1:0] val,
        input bit           pop_at,
        input bit           clr_at
    );
        event_in = 1'b1;
        count    = ~val;
        tick();
        event_in = 1'b0;
        tick();
        count = val;
        if (pop_at) bus.out_ready = 1'b1;
        clear_ovf = clr_at;
        tick();
        count = ~val;
        if (pop_at) bus.out_ready = 1'b0;
        clear_ovf = 1'b0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        count         = '0;
        arm           = 1'b0;
        event_in      = 1'b0;
        clear_ovf     = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        n_total++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL rst_valid got %b exp 0", bus.out_valid);
        else n_pass++;
        n_total++;
        if (level !== '0)
            $display("FAIL rst_level got %0d exp 0", level);
        else n_pass++;
        n_total++;
        if (overflow !== 1'b0 || drop_cnt !== 8'd0)
            $display("FAIL rst_ovf got %b/%0d exp 0/0", overflow, drop_cnt);
        else n_pass++;
        n_total++;
        if (bus.out_data !== '0)
            $display("FAIL rst_data got %h exp 0", bus.out_data);
        else n_pass++;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_total++;
        if (bus.out_valid !== 1'b0 || level !== '0 || bus.out_data !== '0)
            $display("FAIL post_rst got v%b l%0d d%h exp 0", bus.out_valid, level, bus.out_data);
        else n_pass++;
    endtask

    task automatic test_first_capture();
        arm      = 1'b1;
        event_in = 1'b1;
        count    = '0;
        tick();
        event_in = 1'b0;
        tick();
        count = 33'd100;
        n_total++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL early_valid got %b exp 0", bus.out_valid);
        else n_pass++;
        tick();
        count = '0;
        n_total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 33'd100 || level !== 4'd1)
            $display("FAIL first_cap got v%b d%0d l%0d exp v1 d100 l1", bus.out_valid, bus.out_data, level);
        else n_pass++;
        bus.out_ready = 1'b1;
        tick();
        n_total++;
        if (bus.out_valid !== 1'b0 || level !== '0 || bus.out_data !== '0)
            $display("FAIL first_pop got v%b l%0d d%h exp 0", bus.out_valid, level, bus.out_data);
        else n_pass++;
        tick();
        n_total++;
        if (level !== '0)
            $display("FAIL empty_pop got %0d exp 0", level);
        else n_pass++;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_disarmed();
        arm = 1'b0;
        for (int i = 0; i < 3; i++) capture(BASE + W'(i), 1'b0, 1'b0);
        tick();
        n_total++;
        if (level !== '0 || overflow !== 1'b0)
            $display("FAIL disarmed got l%0d o%b exp l0 o0", level, overflow);
        else n_pass++;
        arm = 1'b1;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 10; i++) capture(BASE + W'(i), 1'b0, 1'b0);
        n_total++;
        if (level !== 4'd8 || overflow !== 1'b1 || drop_cnt !== 8'd2)
            $display("FAIL ovf got l%0d o%b c%0d exp l8 o1 c2", level, overflow, drop_cnt);
        else n_pass++;
        tick();
        tick();
        n_total++;
        if (bus.out_data !== BASE || bus.out_valid !== 1'b1)
            $display("FAIL hold got d%h v%b exp d%h v1", bus.out_data, bus.out_valid, BASE);
        else n_pass++;
    endtask

    task automatic test_full_push_pop();
        logic [W-1:0] exp;
        capture(VNEW, 1'b1, 1'b0);
        n_total++;
        if (level !== 4'd8 || overflow !== 1'b1 || drop_cnt !== 8'd2)
            $display("FAIL full_pp got l%0d o%b c%0d exp l8 o1 c2", level, overflow, drop_cnt);
        else n_pass++;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp = (i == 7) ? VNEW : BASE + W'(i + 1);
            n_total++;
            if (bus.out_data !== exp || bus.out_valid !== 1'b1)
                $display("FAIL drain%0d got d%h v%b exp d%h", i, bus.out_data, bus.out_valid, exp);
            else n_pass++;
            tick();
        end
        bus.out_ready = 1'b0;
        n_total++;
        if (level !== '0 || bus.out_valid !== 1'b0)
            $display("FAIL drained got l%0d v%b exp 0", level, bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_clear();
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        n_total++;
        if (overflow !== 1'b0 || drop_cnt !== 8'd0)
            $display("FAIL clear got o%b c%0d exp 0/0", overflow, drop_cnt);
        else n_pass++;
        for (int i = 0; i < 8; i++) capture(BASE2 + W'(i), 1'b0, 1'b0);
        n_total++;
        if (level !== 4'd8 || overflow !== 1'b0)
            $display("FAIL refill got l%0d o%b exp l8 o0", level, overflow);
        else n_pass++;
        capture(BASE2 + W'(99), 1'b0, 1'b1);
        n_total++;
        if (overflow !== 1'b1 || drop_cnt !== 8'd1)
            $display("FAIL clr_drop got o%b c%0d exp o1 c1", overflow, drop_cnt);
        else n_pass++;
        for (int i = 0; i < 300; i++) capture(W'(i), 1'b0, 1'b0);
        n_total++;
        if (drop_cnt !== 8'd255 || overflow !== 1'b1)
            $display("FAIL sat got c%0d o%b exp c255 o1", drop_cnt, overflow);
        else n_pass++;
        n_total++;
        if (level !== 4'd8 || bus.out_data !== BASE2)
            $display("FAIL sat_head got l%0d d%h exp l8 d%h", level, bus.out_data, BASE2);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b1;
        tick();
        tick();
        tick();
        bus.out_ready = 1'b0;
        n_total++;
        if (level !== 4'd5 || bus.out_data !== BASE2 + W'(3))
            $display("FAIL pre_rst got l%0d d%h exp l5", level, bus.out_data);
        else n_pass++;
        event_in = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (level !== '0 || bus.out_valid !== 1'b0 || bus.out_data !== '0)
            $display("FAIL mid_rst got l%0d v%b d%h exp 0", level, bus.out_valid, bus.out_data);
        else n_pass++;
        n_total++;
        if (overflow !== 1'b0 || drop_cnt !== 8'd0)
            $display("FAIL mid_rst_ovf got o%b c%0d exp 0/0", overflow, drop_cnt);
        else n_pass++;
        event_in = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        n_total++;
        if (level !== '0 || bus.out_valid !== 1'b0)
            $display("FAIL post_mid got l%0d v%b exp 0", level, bus.out_valid);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_first_capture();
        test_disarmed();
        test_overflow();
        test_full_push_pop();
        test_clear();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
